wb_arbiter: RTL

Round-robin Wishbone arbiter that sits directly upstream of `wb_intercon` and merges `NM` Wishbone masters onto its single master port. A granted master owns the bus for its whole `cyc` assertion. A watchdog aborts any strobe that the addressed slave never acknowledges, so one dead slave cannot lock out every master.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_rr_pick.sv | 26 ++
 rtl/wb_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } arb_state_t;

    localparam int unsigned WDOG_W = 16;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module wb_rr_pick
    import wb_arb_pkg::*;
#(
    parameter  int unsigned NM = 3,
    localparam int unsigned IW = $clog2(NM)
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Search last+1, last+2, ... modulo NM; 'last' itself is the final candidate.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 1; i <= NM; i++) begin
            if (!any && req[(32'(last) + i) % NM]) begin
                any = 1'b1;
                idx = IW'((32'(last) + i) % NM);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter with per-strobe watchdog abort.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter  int unsigned AW      = 32,
    parameter  int unsigned DW      = 32,
    parameter  int unsigned NM      = 3,
    parameter  int unsigned TIMEOUT = 255,
    localparam int unsigned SEL     = DW / 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NM-1:0]     wbm_cyc_i,
    input  logic [NM-1:0]     wbm_stb_i,
    input  logic [NM-1:0]     wbm_we_i,
    input  logic [NM*SEL-1:0] wbm_sel_i,
    input  logic [NM*AW-1:0]  wbm_adr_i,
    input  logic [NM*DW-1:0]  wbm_dat_i,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [NM-1:0]     wbm_ack_o,
    output logic [NM-1:0]     wbm_err_o,
    output logic              wbs_cyc_o,
    output logic              wbs_stb_o,
    output logic              wbs_we_o,
    output logic [SEL-1:0]    wbs_sel_o,
    output logic [AW-1:0]     wbs_adr_o,
    output logic [DW-1:0]     wbs_dat_o,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic              wbs_ack_i
);

    localparam int unsigned IW = $clog2(NM);

    arb_state_t        state, state_next;
    logic [IW-1:0]     grant, last, pick_idx;
    logic              pick_any;
    logic [WDOG_W-1:0] wdog;
    logic              err_first;
    logic              g_cyc, g_stb, timeout_hit;

    wb_rr_pick #(.NM(NM)) u_pick (
        .req  (wbm_cyc_i),
        .last (last),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign g_cyc       = wbm_cyc_i[grant];
    assign g_stb       = wbm_stb_i[grant];
    assign timeout_hit = g_stb && !wbs_ack_i && (wdog == WDOG_W'(TIMEOUT - 1));
    assign wbm_dat_o   = wbs_dat_i;

    // State register: FSM state, grant/last bookkeeping, watchdog, err pulse flag.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IW'(NM - 1);
            wdog      <= '0;
            err_first <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_any) begin
                grant <= pick_idx;
                last  <= pick_idx;
            end
            if (state != BUSY || wbs_ack_i) begin
                wdog <= '0;
            end else if (g_stb) begin
                wdog <= wdog + WDOG_W'(1);
            end
            err_first <= (state == BUSY) && (state_next == ABORT);
        end
    end

    // Next-state: releasing cyc beats a simultaneous timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_any) state_next = BUSY;
            BUSY:    if (!g_cyc) state_next = IDLE;
                     else if (timeout_hit) state_next = ABORT;
            ABORT:   if (!g_cyc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs: forward the owner in BUSY, err pulse in first ABORT cycle, else zero.
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbm_ack_o = '0;
        wbm_err_o = '0;
        case (state)
            BUSY: begin
                wbs_cyc_o        = g_cyc;
                wbs_stb_o        = g_stb;
                wbs_we_o         = wbm_we_i[grant];
                wbs_sel_o        = wbm_sel_i[grant*SEL +: SEL];
                wbs_adr_o        = wbm_adr_i[grant*AW +: AW];
                wbs_dat_o        = wbm_dat_i[grant*DW +: DW];
                // an ack landing in a reset cycle is dropped; the master retries
                wbm_ack_o[grant] = wbs_ack_i & ~wb_rst_i;
            end
            ABORT:   wbm_err_o[grant] = err_first;
            default: ;
        endcase
    end

endmodule
